if_stage: RTL and testbench

- Instruction-fetch stage of the five-stage core.
- Owns the program counter and drives the fetch address into the unified instruction/data memory. That memory returns pc and inst combinationally in the same cycle.
- Registers the returned pair into the IF/ID pipeline register for the decode stage.
- Handles the decode stall, the pipeline flush and the branch/jump redirect from EX, and counts accepted fetches.

---
 rtl/if_stage.sv | 92 +++++++++
 tb/tb_if_stage.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the fetch address and
// registers the returned pc/instruction pair into the IF/ID register.
module if_stage #(
   parameter int unsigned XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
   parameter logic [XLEN-1:0] NOP_INST = 32'h0000_0013
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            stall_i,
   input  logic            flush_i,
   input  logic            jump_i,
   input  logic [XLEN-1:0] jump_addr_i,
   output logic [XLEN-1:0] rom_addr_o,
   input  logic [XLEN-1:0] rom_pc_i,
   input  logic [XLEN-1:0] rom_inst_i,
   output logic [XLEN-1:0] pc_o,
   output logic [XLEN-1:0] inst_o,
   output logic            valid_o,
   output logic            misalign_o,
   output logic [31:0]     fetch_cnt_o
);

   localparam int unsigned CNT_W = 32;

   logic [XLEN-1:0]  r_pc;
   logic [XLEN-1:0]  r_if_pc;
   logic [XLEN-1:0]  r_if_inst;
   logic             r_if_valid;
   logic             r_misalign;
   logic [CNT_W-1:0] r_fetch_cnt;

   logic [XLEN-1:0]  w_pc_next;
   logic [XLEN-1:0]  w_jump_target;
   logic             w_bubble;
   logic             w_accept;
   logic             w_misalign;

   // Redirect target is forced word-aligned; low bits only feed the flag.
   always_comb begin
      w_jump_target = {jump_addr_i[XLEN-1:2], 2'b00};
      w_misalign    = jump_i & (jump_addr_i[1:0] != 2'b00);
      w_bubble      = jump_i | flush_i;
      w_accept      = ~w_bubble & ~stall_i;
      w_pc_next     = r_pc + XLEN'(4);
      if (jump_i) begin
         w_pc_next = w_jump_target;
      end else if (stall_i) begin
         w_pc_next = r_pc;
      end
   end

   // Program counter; a redirect wins over a stall.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_pc <= RESET_PC;
      end else begin
         r_pc <= w_pc_next;
      end
   end

   // IF/ID pipeline register, misalign flag and accepted-fetch counter.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_if_pc     <= RESET_PC;
         r_if_inst   <= NOP_INST;
         r_if_valid  <= 1'b0;
         r_misalign  <= 1'b0;
         r_fetch_cnt <= '0;
      end else begin
         r_misalign <= w_misalign;
         if (w_bubble) begin
            r_if_pc    <= r_pc;
            r_if_inst  <= NOP_INST;
            r_if_valid <= 1'b0;
         end else if (w_accept) begin
            r_if_pc     <= rom_pc_i;
            r_if_inst   <= rom_inst_i;
            r_if_valid  <= 1'b1;
            r_fetch_cnt <= r_fetch_cnt + CNT_W'(1);
         end
      end
   end

   assign rom_addr_o  = r_pc;
   assign pc_o        = r_if_pc;
   assign inst_o      = r_if_inst;
   assign valid_o     = r_if_valid;
   assign misalign_o  = r_misalign;
   assign fetch_cnt_o = r_fetch_cnt;

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage with a combinational memory model.
module tb_if_stage;

   localparam int unsigned XLEN = 32;
   localparam logic [31:0] NOP  = 32'h0000_0013;

   logic            clk_i = 1'b0;
   logic            rst_i = 1'b1;
   logic            stall_i = 1'b0;
   logic            flush_i = 1'b0;
   logic            jump_i = 1'b0;
   logic [XLEN-1:0] jump_addr_i = '0;
   logic [XLEN-1:0] rom_addr_o;
   logic [XLEN-1:0] rom_pc_i;
   logic [XLEN-1:0] rom_inst_i;
   logic [XLEN-1:0] pc_o;
   logic [XLEN-1:0] inst_o;
   logic            valid_o;
   logic            misalign_o;
   logic [31:0]     fetch_cnt_o;

   int total = 0;
   int bad   = 0;

   if_stage dut (
      .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
      .jump_i(jump_i), .jump_addr_i(jump_addr_i), .rom_addr_o(rom_addr_o),
      .rom_pc_i(rom_pc_i), .rom_inst_i(rom_inst_i), .pc_o(pc_o),
      .inst_o(inst_o), .valid_o(valid_o), .misalign_o(misalign_o),
      .fetch_cnt_o(fetch_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   // Memory: two real instructions at 0 and 4, an address-derived pattern elsewhere.
   function automatic logic [31:0] mem(input logic [31:0] a);
      if (a == 32'h0) return 32'h0010_0093;
      if (a == 32'h4) return 32'h0020_0113;
      return 32'hC0DE_0000 ^ a;
   endfunction

   assign rom_pc_i   = rom_addr_o;
   assign rom_inst_i = mem(rom_addr_o);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk_ifid(input string tag, input logic [31:0] epc, input logic [31:0] einst,
                           input logic ev, input logic [31:0] ecnt, input logic [31:0] eaddr);
      chk({tag, ".pc"},   pc_o, epc);
      chk({tag, ".inst"}, inst_o, einst);
      chk({tag, ".valid"}, 32'(valid_o), 32'(ev));
      chk({tag, ".cnt"},  fetch_cnt_o, ecnt);
      chk({tag, ".addr"}, rom_addr_o, eaddr);
   endtask

   initial begin
      // 1. reset then run
      step(); step();
      chk_ifid("rst", 32'h0, NOP, 1'b0, 32'd0, 32'h0);
      chk("rst.mis", 32'(misalign_o), 32'd0);
      rst_i = 1'b0;
      step();
      chk_ifid("run0", 32'h0, 32'h0010_0093, 1'b1, 32'd1, 32'h4);
      step();
      chk_ifid("run1", 32'h4, 32'h0020_0113, 1'b1, 32'd2, 32'h8);

      // 2. stall hold at pc_q=8
      stall_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_ifid("stall", 32'h4, 32'h0020_0113, 1'b1, 32'd2, 32'h8);
      end
      stall_i = 1'b0;
      step();
      chk_ifid("rel", 32'h8, 32'hC0DE_0008, 1'b1, 32'd3, 32'hC);
      step();
      chk_ifid("run2", 32'hC, 32'hC0DE_000C, 1'b1, 32'd4, 32'h10);

      // 3. redirect during stall at pc_q=0x10
      stall_i = 1'b1; jump_i = 1'b1; jump_addr_i = 32'h40;
      step();
      chk_ifid("jstall", 32'h10, NOP, 1'b0, 32'd4, 32'h40);
      chk("jstall.mis", 32'(misalign_o), 32'd0);
      stall_i = 1'b0; jump_i = 1'b0;
      step();
      chk_ifid("jtgt", 32'h40, 32'hC0DE_0040, 1'b1, 32'd5, 32'h44);

      // 4. misaligned target
      jump_i = 1'b1; jump_addr_i = 32'h46;
      step();
      chk_ifid("mis", 32'h44, NOP, 1'b0, 32'd5, 32'h44);
      chk("mis.flag1", 32'(misalign_o), 32'd1);
      jump_i = 1'b0;
      step();
      chk("mis.flag0", 32'(misalign_o), 32'd0);
      chk_ifid("mistgt", 32'h44, 32'hC0DE_0044, 1'b1, 32'd6, 32'h48);

      // 5. flush only at pc_q=0x20
      jump_i = 1'b1; jump_addr_i = 32'h20;
      step();
      chk_ifid("j20", 32'h48, NOP, 1'b0, 32'd6, 32'h20);
      jump_i = 1'b0; flush_i = 1'b1;
      step();
      chk_ifid("flush", 32'h20, NOP, 1'b0, 32'd6, 32'h24);
      flush_i = 1'b0;
      step();
      chk_ifid("postfl", 32'h24, 32'hC0DE_0024, 1'b1, 32'd7, 32'h28);
      // flush with stall: PC holds, IF/ID becomes the bubble
      flush_i = 1'b1; stall_i = 1'b1;
      step();
      chk_ifid("flstall", 32'h28, NOP, 1'b0, 32'd7, 32'h28);
      flush_i = 1'b0; stall_i = 1'b0;
      step();
      chk_ifid("postfs", 32'h28, 32'hC0DE_0028, 1'b1, 32'd8, 32'h2C);

      // 6. wrap, then reset together with jump
      jump_i = 1'b1; jump_addr_i = 32'hFFFF_FFFC;
      step();
      chk_ifid("jtop", 32'h2C, NOP, 1'b0, 32'd8, 32'hFFFF_FFFC);
      jump_i = 1'b0;
      step();
      chk_ifid("wrap", 32'hFFFF_FFFC, 32'h3F21_FFFC, 1'b1, 32'd9, 32'h0);
      rst_i = 1'b1; jump_i = 1'b1; jump_addr_i = 32'h46; stall_i = 1'b1; flush_i = 1'b1;
      step();
      chk_ifid("rst2", 32'h0, NOP, 1'b0, 32'd0, 32'h0);
      chk("rst2.mis", 32'(misalign_o), 32'd0);
      rst_i = 1'b0; jump_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
      step();
      chk_ifid("rerun", 32'h0, 32'h0010_0093, 1'b1, 32'd1, 32'h4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
